// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: parity modes, RX FSM encoding and a
// width helper that never returns zero.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_START      = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_STOP       = 3'd4;
  localparam logic [2:0] S_BREAK_WAIT = 3'd5;

  // Counter width for n states; at least one bit so degenerate sizes still elaborate.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 2) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for an asynchronous, idle-high input; every stage resets to 1.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, 1-2 stop bits and a
// valid/ready output stage that drops (and flags) frames arriving while one is unread.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TICK_W = clog2_safe(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = clog2_safe(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF     = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST     = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD_MODE  = (PARITY == PAR_ODD);

  logic rx_s;

  logic [2:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 commit_q, commit_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  uart_rx_sync #(
    .STAGES(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    commit_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_DATA_LAST) begin
            bit_d      = '0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            state_d    = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          bit_d     = '0;
          par_err_d = (^shift_q) ^ rx_s ^ PAR_ODD_MODE;
          state_d   = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d     = '0;
          bit_d      = bit_q + 1'b1;
          stop_err_d = stop_err_q | ~rx_s;
          if (bit_q == BIT_STOP_LAST) begin
            commit_d = 1'b1;
            // A low final stop bit means a break; wait for the line to rise first.
            state_d  = rx_s ? S_IDLE : S_BREAK_WAIT;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_BREAK_WAIT: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (commit_q) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        perr_d  = par_err_q;
        ferr_d  = stop_err_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: a default instance (8N1) and an even-parity, two-stop instance,
// driven with directed frames, a vector table and random frames checked against a model.
module tb_uart_rx_os;

  localparam int CLKS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic [1:0] st;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_a = 1'b1, ready_a = 1'b1, rx_p = 1'b1, ready_p = 1'b1;
  logic [7:0] data_a, data_p;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_p, perr_p, ferr_p, ovr_p, busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  frm_t cap_a[$];
  frm_t cap_p[$];
  int ovr_cnt_a = 0, vhi_a = 0, rises_a = 0, rise_cyc_a = -1;
  logic vprev_a = 1'b0;

  vec_t tbl[6];
  int t0;
  logic [7:0] rd;
  logic rp;
  logic [1:0] rs;

  uart_rx_os u_a (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_a),
    .data_out  (data_a),
    .valid     (valid_a),
    .ready     (ready_a),
    .parity_err(perr_a),
    .frame_err (ferr_a),
    .overrun   (ovr_a),
    .busy      (busy_a)
  );

  uart_rx_os #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(16),
    .PARITY      (1),
    .STOP_BITS   (2)
  ) u_p (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_p),
    .data_out  (data_p),
    .valid     (valid_p),
    .ready     (ready_p),
    .parity_err(perr_p),
    .frame_err (ferr_p),
    .overrun   (ovr_p),
    .busy      (busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer-side monitor: records every accepted frame and the output activity.
  always @(negedge clk) begin
    if (valid_a && ready_a) cap_a.push_back({data_a, perr_a, ferr_a});
    if (valid_p && ready_p) cap_p.push_back({data_p, perr_p, ferr_p});
    if (ovr_a) ovr_cnt_a++;
    if (valid_a) vhi_a++;
    if (valid_a && !vprev_a) begin
      rises_a++;
      rise_cyc_a = cyc;
    end
    vprev_a = valid_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line bits of a frame: start 0, data LSB first, optional parity, stop bits (st[0] first).
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic p,
                            input logic [1:0] st, input int gap_bits);
    logic [15:0] bits;
    int n;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (sel) begin
      bits[9]  = p;
      bits[10] = st[0];
      bits[11] = st[1];
      n = 12;
    end else begin
      bits[9] = st[0];
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      if (sel) rx_p = bits[i];
      else rx_a = bits[i];
      repeat (CLKS) @(posedge clk);
      #1;
    end
    if (sel) rx_p = 1'b1;
    else rx_a = 1'b1;
    repeat (gap_bits * CLKS) @(posedge clk);
    #1;
  endtask

  // Reference: even parity over data plus parity bit must be even; any low stop bit is an error.
  function automatic frm_t model(input bit sel, input logic [7:0] d, input logic p,
                                 input logic [1:0] st);
    frm_t f;
    f.d  = d;
    f.pe = sel ? ((($countones(d) + int'(p)) % 2) == 1) : 1'b0;
    f.fe = sel ? (st != 2'b11) : !st[0];
    return f;
  endfunction

  task automatic expect_frame(input bit sel, input string name, input frm_t exp);
    frm_t got;
    int sz;
    sz = sel ? cap_p.size() : cap_a.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no frame expected data %0h", name, exp.d);
    end else begin
      if (sel) got = cap_p.pop_front();
      else got = cap_a.pop_front();
      check({name, " data"}, 32'(got.d), 32'(exp.d));
      check({name, " parity_err"}, 32'(got.pe), 32'(exp.pe));
      check({name, " frame_err"}, 32'(got.fe), 32'(exp.fe));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " data_out"}, 32'(data_a), 32'h0);
    check({name, " valid"}, 32'(valid_a), 32'h0);
    check({name, " parity_err"}, 32'(perr_a), 32'h0);
    check({name, " frame_err"}, 32'(ferr_a), 32'h0);
    check({name, " overrun"}, 32'(ovr_a), 32'h0);
    check({name, " busy"}, 32'(busy_a), 32'h0);
  endtask

  initial begin
    tbl[0] = '{8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 2'b10, 8'h81, 1'b0, 1'b1};
    tbl[5] = '{8'h5A, 1'b1, 2'b01, 8'h5A, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset p valid", 32'(valid_p), 32'h0);
    check("reset p busy", 32'(busy_p), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 0xA5 on 8N1: latency counted from the first edge that samples rx low
    vhi_a = 0;
    rise_cyc_a = -1;
    t0 = cyc;
    send_frame(1'b0, 8'hA5, 1'b0, 2'b11, 2);
    check("a5 latency", 32'(rise_cyc_a - (t0 + 1)), 32'd155);
    check("a5 valid cycles", 32'(vhi_a), 32'd1);
    expect_frame(1'b0, "a5", '{8'hA5, 1'b0, 1'b0});

    // 5-clock glitch: false start rejected, back to idle within 12 clocks
    rises_a = 0;
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (1) @(posedge clk);
    @(negedge clk);
    check("glitch busy mid", 32'(busy_a), 32'h1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("glitch busy end", 32'(busy_a), 32'h0);
    @(posedge clk);
    #1;
    repeat (2 * CLKS) @(posedge clk);
    #1;
    check("glitch no valid", 32'(rises_a), 32'h0);

    // Even parity / two stop bits vector table
    foreach (tbl[i]) begin
      send_frame(1'b1, tbl[i].d, tbl[i].p, tbl[i].st, 2);
      expect_frame(1'b1, $sformatf("vec%0d", i), '{tbl[i].ed, tbl[i].epe, tbl[i].efe});
    end

    // Low stop bit then 40 bit times of break: exactly one frame, then clean 0x5A
    rises_a = 0;
    send_frame(1'b0, 8'hC3, 1'b0, 2'b10, 0);
    rx_a = 1'b0;
    repeat (20 * CLKS) @(posedge clk);
    @(negedge clk);
    check("break busy", 32'(busy_a), 32'h1);
    repeat (20 * CLKS) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (2 * CLKS) @(posedge clk);
    #1;
    check("break one valid", 32'(rises_a), 32'd1);
    expect_frame(1'b0, "break frame", '{8'hC3, 1'b0, 1'b1});
    send_frame(1'b0, 8'h5A, 1'b0, 2'b11, 2);
    expect_frame(1'b0, "after break", '{8'h5A, 1'b0, 1'b0});

    // Overrun: ready low, two back-to-back frames
    ready_a = 1'b0;
    ovr_cnt_a = 0;
    send_frame(1'b0, 8'h11, 1'b0, 2'b11, 0);
    send_frame(1'b0, 8'h22, 1'b0, 2'b11, 2);
    @(negedge clk);
    check("ovr valid held", 32'(valid_a), 32'h1);
    check("ovr data kept", 32'(data_a), 32'h11);
    check("ovr pulses", 32'(ovr_cnt_a), 32'd1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr valid drops", 32'(valid_a), 32'h0);
    expect_frame(1'b0, "ovr frame", '{8'h11, 1'b0, 1'b0});
    check("ovr no second", 32'(cap_a.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of data bit 4 of 0x33
    rx_a = 1'b0;
    repeat (CLKS) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx_a = ((8'h33 >> i) & 8'h1) != 0;
      repeat (CLKS) @(posedge clk);
    end
    #1 rx_a = 1'b1;
    repeat (CLKS / 2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid reset");
    @(posedge clk);
    #1;
    repeat (6 * CLKS) @(posedge clk);
    #1;
    check("mid reset no frame", 32'(cap_a.size()), 32'd0);
    send_frame(1'b0, 8'h44, 1'b0, 2'b11, 2);
    expect_frame(1'b0, "after reset", '{8'h44, 1'b0, 1'b0});

    // Random frames on both instances against the model
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(1'b0, rd, rp, rs, 2);
      expect_frame(1'b0, $sformatf("rnd a%0d", i), model(1'b0, rd, rp, rs));
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(1'b1, rd, rp, rs, 2);
      expect_frame(1'b1, $sformatf("rnd p%0d", i), model(1'b1, rd, rp, rs));
    end
    check("no stray a", 32'(cap_a.size()), 32'd0);
    check("no stray p", 32'(cap_p.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampled UART receiver; next generation of the bit-level RX block.
- Adds a 2-flop input synchroniser and mid-bit sampling from a clock-divided bit timer.
- Adds configurable data width, parity and stop bits, plus per-frame parity/framing error flags.
- Adds a valid/ready output handshake with overrun detection. Sits between the pad-level rx pin and the command/loader logic of the CPU.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
- CLKS_PER_BIT, 16, clk cycles per bit period, legal >=4, even.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits, legal 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous UART line, idle high
- data_out  out  DATA_BITS  received word; stable while valid=1
- valid  out  1  data_out/error flags hold a frame
- ready  in  1  consumer accepts the frame when valid&&ready at a rising clk edge
- parity_err  out  1  parity mismatch for the frame in data_out; always 0 when PARITY=0
- frame_err  out  1  a stop bit was sampled 0 for the frame in data_out
- overrun  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  FSM is not in IDLE

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: sync flops=1, state=IDLE, data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame abandons the frame; no output is produced.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Bit timer: tick_cnt has width $clog2(CLKS_PER_BIT). bit_cnt has width $clog2(DATA_BITS+1).
- State IDLE: when rx_s==0, go to START with tick_cnt=0.
- State START: at tick_cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 0: go to DATA, tick_cnt=0, bit_cnt=0.
  - Sample 1: false start, return to IDLE with no output.
- State DATA: at each tick_cnt==CLKS_PER_BIT-1, shift rx_s into shift_reg[bit_cnt] and increment bit_cnt.
  - After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- State PARITY: sample one bit p.
  - Even mode: error when XOR(data)^p==1.
  - Odd mode: error when XOR(data)^p==0.
- State STOP: sample STOP_BITS bits. frame_err_next = OR of the inverted samples.
- Commit occurs on the cycle after the final stop sample:
  - data_out<=shift_reg; parity_err and frame_err are loaded; valid<=1.
  - Then go to IDLE, or to BREAK_WAIT if the last stop sample was 0.
- State BREAK_WAIT: stay until rx_s==1, then go to IDLE. A held-low line must not retrigger.
- Latency from the rx falling edge to valid rising: 2 + CLKS_PER_BIT/2 + CLKS_PER_BIT*(DATA_BITS+(PARITY!=0)+STOP_BITS) + 1 clocks. This is 155 for 16/8/none/1.
- Handshake:
  - valid stays high until accepted.
  - data_out and the flags hold stable while valid=1.
  - On acceptance with no commit in the same cycle, valid<=0.
- Commit while valid=1 && !ready: the new frame is discarded, old data is kept, and overrun pulses for 1 cycle.
- Commit and acceptance in the same cycle: the new frame loads, valid stays 1, no overrun.
- Frames with errors are still delivered. The flags describe that frame only, with no stickiness.
- busy=1 in START, DATA, PARITY, STOP and BREAK_WAIT.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the RX state encoding IDLE, START, DATA, PARITY, STOP, BREAK_WAIT (3 bits);
  - the function clog2-safe width helper.
- One sub-module, uart_rx_sync: the parametrised N-flop synchroniser with reset value 1. Everything else stays in one FSM module.

Test Plan:
- Defaults, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), ready=1 → valid for exactly 1 cycle, 155 clocks after the falling edge, data_out=0xA5, parity_err=0, frame_err=0.
- 0.3-bit low glitch (5 clocks) on an idle line → no valid, busy returns to 0 by clock 12, FSM in IDLE.
- PARITY=1, send 0x03 with parity bit 1 → parity_err=1, data_out=0x03. Then 0x07 with parity bit 1 → parity_err=0.
- Stop bit forced 0 followed by the line held low for 40 bit times, then high, then 0x5A → first frame frame_err=1 with one valid. No frames during the low period. Then 0x5A is received clean.
- ready=0, send 0x11 then 0x22 back to back → data_out stays 0x11, overrun pulses once at the 0x22 commit. With ready=1, 0x11 is consumed and valid drops.
- Assert reset for 1 cycle in the middle of data bit 4 of 0x33, then send 0x44 → no output for 0x33, 0x44 is received correctly, all outputs 0 on the cycle after reset.
